// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel-load / serial-out bus bundle.
// The master drives the word and strobes; the slave returns the line and status.
interface piso_serializer_if #(
  parameter int N = 10
);
  logic [N-1:0] d;
  logic         load;
  logic         ena;
  logic         q;
  logic         ready;
  logic         busy;
  logic         done;

  modport master (
    output d,
    output load,
    output ena,
    input  q,
    input  ready,
    input  busy,
    input  done
  );

  modport slave (
    input  d,
    input  load,
    input  ena,
    output q,
    output ready,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first PISO transmitter paced by an ena strobe.
// Define PISO_PARITY_EN to append an even-parity bit after the LSB.
module piso_serializer #(
  parameter int N = 10
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);
  localparam int CW = $clog2(N + 2);
`ifdef PISO_PARITY_EN
  localparam int LAST = N;
`else
  localparam int LAST = N - 1;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
`ifdef PISO_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        // ena in the load cycle is dropped so bit 0 gets a full strobe
        if (bus.load) begin
          sr_d    = bus.d;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^bus.d;
`endif
        end
      end
      SHIFT: begin
        if (bus.ena) begin
          sr_d  = {sr_q[N-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic shift_bit;
`ifdef PISO_PARITY_EN
  assign shift_bit = (cnt_q == CW'(N)) ? par_q : sr_q[N-1];
`else
  assign shift_bit = sr_q[N-1];
`endif

  assign bus.q     = (state_q == SHIFT) ? shift_bit : 1'b1;
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of framing, pacing, abort.
// Parity cases run only when PISO_PARITY_EN is defined.
module tb_piso_serializer;
  localparam int N = 10;
`ifdef PISO_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.N(N)) bus ();

  piso_serializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".q"},     32'(bus.q),     32'd1);
    chk({tag, ".ready"}, 32'(bus.ready), 32'd1);
    chk({tag, ".busy"},  32'(bus.busy),  32'd0);
  endtask

  // Issue the load edge; afterwards we sit in cycle 1 of the frame.
  task automatic start(input logic [N-1:0] w);
    bus.d    = w;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  // With ena held high: walk NB bits, then expect done.
  task automatic run_fast(input string tag, input logic [N:0] bits);
    bus.ena = 1'b1;
    for (int i = 0; i < NB; i++) begin
      chk({tag, ".q"},    32'(bus.q),    32'(bits[NB-1-i]));
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
      tick();
    end
    chk({tag, ".done_end"}, 32'(bus.done), 32'd1);
    chk_idle({tag, ".end"});
  endtask

  logic [N:0] fr;

  initial begin
    rst      = 1'b1;
    bus.d    = '1;
    bus.load = 1'b1;
    bus.ena  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("rst");
      chk("rst.done", 32'(bus.done), 32'd0);
    end
    rst      = 1'b0;
    bus.load = 1'b0;
    bus.ena  = 1'b0;
    tick();
    chk_idle("post_rst");

    // basic frame 10'h2A5, ena with load is ignored
    bus.ena = 1'b1;
`ifdef PISO_PARITY_EN
    fr = {10'h2A5, 1'b1};
`else
    fr = {1'b0, 10'h2A5};
`endif
    start(10'h2A5);
    run_fast("basic", fr);
    tick();
    chk("basic.done_clr", 32'(bus.done), 32'd0);

    // slow strobe: one ena every 4th cycle
    bus.ena = 1'b0;
    start(10'h3FF);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++) begin
        bus.ena = (c == 3);
`ifdef PISO_PARITY_EN
        chk("slow.q", 32'(bus.q), (b == N) ? 32'd0 : 32'd1);
`else
        chk("slow.q", 32'(bus.q), 32'd1);
`endif
        chk("slow.busy", 32'(bus.busy), 32'd1);
        chk("slow.done", 32'(bus.done), 32'd0);
        tick();
      end
    end
    bus.ena = 1'b0;
    chk("slow.done_end", 32'(bus.done), 32'd1);
    tick();
    chk("slow.done_clr", 32'(bus.done), 32'd0);

    // mid-frame load is ignored, then back-to-back load on done
    bus.ena = 1'b1;
    start(10'h155);
`ifdef PISO_PARITY_EN
    fr = {10'h155, 1'b1};
`else
    fr = {1'b0, 10'h155};
`endif
    for (int i = 0; i < NB; i++) begin
      bus.load = (i == 3);
      bus.d    = (i == 3) ? 10'h000 : 10'h155;
      chk("ign.q", 32'(bus.q), 32'(fr[NB-1-i]));
      chk("ign.ready", 32'(bus.ready), 32'd0);
      tick();
    end
    bus.load = 1'b0;
    chk("ign.done", 32'(bus.done), 32'd1);
    start(10'h001);
`ifdef PISO_PARITY_EN
    fr = {10'h001, 1'b1};
`else
    fr = {1'b0, 10'h001};
`endif
    run_fast("b2b", fr);

    // abort after the 4th bit
    start(10'h155);
    for (int i = 0; i < 4; i++) tick();
    chk("abort.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort");
    chk("abort.done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort.nodone", 32'(bus.done), 32'd0);
    end

`ifdef PISO_PARITY_EN
    start(10'h007);
    run_fast("par7", {10'h007, 1'b1});
    start(10'h003);
    run_fast("par3", {10'h003, 1'b0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
